// File: rtl/clk_activity_monitor_pkg.sv
// Shared types and constants for the clock activity monitor.
// Imported by the synchronizer and the top-level monitor.
package clk_activity_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Cycles spent flushing the synchronizer before a window starts.
  localparam int ARM_CYCLES = 2;

endpackage

// File: rtl/clk_activity_monitor_sync.sv
// Brings the monitored clock into the CLK domain (two flops) and adds a
// third flop so a rising edge appears as a one-cycle RISE pulse.
module clk_activity_monitor_sync (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  output logic RISE
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= I;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Edge flop boundary: new high on sync_p1 not yet seen by sync_p2.
  assign RISE = sync_p1 & ~sync_p2;

endmodule

// File: rtl/clk_activity_monitor.sv
// Counts rising edges of a monitored clock over fixed windows and flags
// out-of-range frequency (FAULT) and a stalled clock (STUCK).
// Optional build macro CLK_ACTIVITY_MONITOR_STICKY_EN makes both flags sticky
// and adds a synchronous CLR input.
module clk_activity_monitor
  import clk_activity_monitor_pkg::*;
#(
  parameter int WIN_CYCLES   = 256,
  parameter int CNT_W        = 8,
  parameter int MIN_EDGES    = 100,
  parameter int MAX_EDGES    = 128,
  parameter int STUCK_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I,
  input  logic             EN,
`ifdef CLK_ACTIVITY_MONITOR_STICKY_EN
  input  logic             CLR,
`endif
  output logic [CNT_W-1:0] CNT,
  output logic             VALID,
  output logic             FAULT,
  output logic             STUCK,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [1:0]       ARM_LAST = 2'(ARM_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STUCK_CYCLES);

  state_t             state;
  state_t             state_next;
  logic               rise;
  logic [1:0]         arm_ctr;
  logic [WIN_W-1:0]   win_ctr;
  logic [CNT_W-1:0]   edge_ctr;
  logic [CNT_W-1:0]   edge_final;
  logic [STK_W-1:0]   stk_ctr;
  logic               report_load;
  logic               bad_window;
  logic               stuck_live;
  logic [CNT_W-1:0]   cnt_q;
  logic               fault_q;

  function automatic logic [CNT_W-1:0] sat_inc_edge(input logic [CNT_W-1:0] c,
                                                    input logic inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    return c;
  endfunction

  function automatic logic [STK_W-1:0] sat_inc_stuck(input logic [STK_W-1:0] c);
    if (c != STK_MAX)
      return c + STK_W'(1);
    return c;
  endfunction

  function automatic logic out_of_range(input logic [CNT_W-1:0] c);
    return (32'(c) < MIN_EDGES) || (32'(c) > MAX_EDGES);
  endfunction

  clk_activity_monitor_sync u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .I    (I),
    .RISE (rise)
  );

  // Last COUNT cycle: fold in this cycle's edge so it lands in the report.
  assign report_load = (state == COUNT) && (win_ctr == WIN_LAST);
  assign edge_final  = sat_inc_edge(edge_ctr, rise);
  assign bad_window  = out_of_range(edge_final);
  assign stuck_live  = (stk_ctr == STK_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    VALID      = 1'b0;
    case (state)
      IDLE:    if (EN) state_next = ARM;
      ARM:     if (arm_ctr == ARM_LAST) state_next = COUNT;
      COUNT:   if (win_ctr == WIN_LAST) state_next = REPORT;
      REPORT: begin
        VALID      = 1'b1;
        state_next = EN ? COUNT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      arm_ctr  <= '0;
      win_ctr  <= '0;
      edge_ctr <= '0;
    end else begin
      arm_ctr  <= (state == ARM)   ? arm_ctr + 2'd1 : 2'd0;
      win_ctr  <= (state == COUNT) ? win_ctr + WIN_W'(1) : '0;
      edge_ctr <= (state == COUNT) ? edge_final : '0;
    end
  end

  // Stall detector runs across window boundaries but sleeps in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      stk_ctr <= '0;
    else if ((state == IDLE) || rise)
      stk_ctr <= '0;
    else
      stk_ctr <= sat_inc_stuck(stk_ctr);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt_q <= '0;
    else if (report_load)
      cnt_q <= edge_final;
  end

`ifdef CLK_ACTIVITY_MONITOR_STICKY_EN
  logic stuck_hold;

  // A flag being raised this cycle beats a coincident CLR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fault_q    <= 1'b0;
      stuck_hold <= 1'b0;
    end else begin
      fault_q    <= (report_load & bad_window) | (fault_q & ~CLR);
      stuck_hold <= stuck_live | (stuck_hold & ~CLR);
    end
  end

  assign STUCK = stuck_live | stuck_hold;
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      fault_q <= 1'b0;
    else if (report_load)
      fault_q <= bad_window;
  end

  assign STUCK = stuck_live;
`endif

  assign CNT   = cnt_q;
  assign FAULT = fault_q;

endmodule
